toggle_event_rx: RTL and testbench
==================================

Name: toggle_event_rx

Overview:
- Destination-side receiver for a bank of toggle-encoded events from an asynchronous source.
- Each channel's source flips its level once per event.
- Per channel, the block:
  - synchronises the level through a parametrised flop chain;
  - converts each level change into a one-cycle pulse;
  - queues the pulse as a pending-event count that a consumer drains with a valid/ready handshake, so no event is lost under backpressure.
- Sits at the clock-domain boundary wherever event bursts must cross domains faster than a consumer can act on them.

Parameters:
- CH, 4, number of independent event channels (>=1).
- SYNC_STAGES, 2, synchroniser depth per channel (>=2).
- CNT_W, 4, pending-event counter width per channel (>=1); saturates at 2^CNT_W-1.

Ports:
- clk  input  1  destination clock.
- rst_n  input  1  asynchronous active-low reset.
- tgl_in  input  CH  asynchronous toggle levels, one bit per channel; each transition is one event.
- evt_pulse  output  CH  one-cycle pulse per detected transition.
- evt_vld  output  CH  channel has >=1 pending event.
- evt_rdy  input  CH  consumer accepts one event per channel when evt_vld&evt_rdy.
- evt_cnt  output  CH*CNT_W  pending count; channel i at bits [i*CNT_W +: CNT_W].
- ovf  output  CH  sticky: an event was dropped because the counter was saturated.
- ovf_clr  input  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (async assert, sync release by the integrator):
  - all sync flops, history flops, counters and ovf = 0;
  - evt_pulse=0, evt_vld=0, evt_cnt=0.
- Source toggles reset to 0. A source that exits reset at 1 produces one event; this is intended, not filtered.
- Sync chain per channel:
  - stage[0] samples tgl_in[i];
  - stage[k] samples stage[k-1];
  - hist samples stage[SYNC_STAGES-1].
  - No logic between tgl_in and stage[0].
- evt_pulse[i] = stage[SYNC_STAGES-1] ^ hist, decoded from flops only (glitch-free).
- Latency, with tgl_in stable before edge 1:
  - evt_pulse high from edge SYNC_STAGES to edge SYNC_STAGES+1, exactly one cycle;
  - counter updated at edge SYNC_STAGES+1.
- Minimum source toggle spacing is SYNC_STAGES+1 destination cycles. Closer toggles may merge and cancel; this is not detected.
- Counter per channel, updated each edge (inc = evt_pulse, pop = evt_vld & evt_rdy):
  - inc & !pop: cnt+1 if cnt < max; else cnt holds and ovf set;
  - !inc & pop: cnt-1;
  - inc & pop: cnt unchanged, including at max (no overflow);
  - neither: hold.
- evt_vld[i] = (cnt != 0), combinational from the counter register.
- evt_rdy with evt_vld=0 is ignored; no underflow is possible.
- ovf:
  - set wins over ovf_clr in the same cycle;
  - otherwise ovf_clr clears all channels at the next edge.
- Channels are fully independent; simultaneous events on all channels are each counted.
- Reset mid-operation discards all pending counts and in-flight sync state immediately.

Test Plan:
- Reset: hold rst_n=0, toggle tgl_in -> all outputs stay 0. Release with tgl_in=0 -> no pulse.
- Single event, ch0, SYNC_STAGES=2: flip tgl_in[0] before edge 1 ->
  - evt_pulse[0] high for exactly the cycle after edge 2;
  - evt_cnt[0]=1 and evt_vld[0]=1 after edge 3;
  - evt_rdy[0]=1 for one cycle -> cnt=0, evt_vld=0.
- Backpressure: 5 toggles spaced 4 cycles apart on ch2 with evt_rdy=0 -> evt_cnt[2]=5. Then evt_rdy=1 -> evt_vld drops after exactly 5 cycles.
- Saturation, CNT_W=4: 17 events with evt_rdy=0 -> evt_cnt=15, ovf[i]=1 after the 16th event. ovf_clr pulse -> ovf=0, cnt stays 15.
- Simultaneous inc and pop at cnt=15 -> cnt stays 15, ovf not set. ovf set event coincident with ovf_clr -> ovf=1.
- Multi-channel: toggle all 4 channels on the same cycle -> all evt_pulse high the same cycle, each evt_cnt=1. Assert rst_n=0 mid-burst -> counts 0 immediately.

Source files
------------

// File: rtl/toggle_event_rx.sv
// -----------------------------------------------------------------------------
// toggle_event_rx
//   Destination-side receiver for a bank of toggle-encoded events arriving from
//   an asynchronous source. Every level change on a channel is one event. Each
//   channel synchronises its level, turns each change into a one-cycle pulse
//   and accumulates pulses in a saturating pending counter that a consumer
//   drains with valid/ready, so bursts survive consumer backpressure.
//
// Ports
//   clk        destination clock
//   rst_n      asynchronous active-low reset
//   tgl_in     [CH]        asynchronous toggle levels, one per channel
//   evt_pulse  [CH]        one-cycle pulse per detected transition
//   evt_vld    [CH]        channel has at least one pending event
//   evt_rdy    [CH]        consumer takes one event when evt_vld & evt_rdy
//   evt_cnt    [CH*CNT_W]  pending count, channel i at [i*CNT_W +: CNT_W]
//   ovf        [CH]        sticky: an event was dropped at a saturated counter
//   ovf_clr                clears all ovf bits at the next edge
// -----------------------------------------------------------------------------

// Per-channel lane: synchroniser, edge detect, pending counter, overflow flag.
module toggle_event_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgl,
    input  logic             rdy,
    input  logic             ovf_clr,
    output logic             pulse,
    output logic             vld,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // sync_q[0] is the first (metastability-catching) stage; tgl feeds it
    // directly with no logic in front.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   inc;
    logic                   pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both operands are flops, so the pulse is a clean decode of state.
    assign pulse = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign vld   = (cnt != '0);
    assign inc   = pulse;
    assign pop   = vld & rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            // Simultaneous inc and pop cancel, even at saturation, so no
            // event is lost in that case.
            if (inc && !pop) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else if (!inc && pop) begin
                cnt <= cnt - 1'b1;
            end
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (inc && !pop && (cnt == CNT_MAX)) ovf <= 1'b1;
            else if (ovf_clr)                    ovf <= 1'b0;
        end
    end
endmodule

module toggle_event_rx #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       tgl_in,
    output logic [CH-1:0]       evt_pulse,
    output logic [CH-1:0]       evt_vld,
    input  logic [CH-1:0]       evt_rdy,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic [CH-1:0]       ovf,
    input  logic                ovf_clr
);
    for (genvar g = 0; g < CH; g++) begin : g_lane
        toggle_event_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .tgl     (tgl_in[g]),
            .rdy     (evt_rdy[g]),
            .ovf_clr (ovf_clr),
            .pulse   (evt_pulse[g]),
            .vld     (evt_vld[g]),
            .cnt     (evt_cnt[g*CNT_W +: CNT_W]),
            .ovf     (ovf[g])
        );
    end
endmodule

// File: tb/tb_toggle_event_rx.sv
// Randomised and directed bench for toggle_event_rx. The reference model keeps,
// per channel, a list of cycles at which a pulse is due, a pending-event
// integer and an overflow bit, all derived from the block's event rules.
module tb_toggle_event_rx;
    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    tgl_in = '0;
    logic [CH-1:0]    evt_rdy = '0;
    logic             ovf_clr = 1'b0;
    logic [CH-1:0]    evt_pulse, evt_vld, ovf;
    logic [CH*CW-1:0] evt_cnt;

    toggle_event_rx #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgl_in    (tgl_in),
        .evt_pulse (evt_pulse),
        .evt_vld   (evt_vld),
        .evt_rdy   (evt_rdy),
        .evt_cnt   (evt_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int m_cnt    [CH];
    bit m_ovf    [CH];
    bit m_lvl    [CH];
    int last_tgl [CH];
    int m_due    [CH][$];

    logic [CH-1:0] tv = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_pulse(input int i);
        foreach (m_due[i][j]) if (m_due[i][j] == cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return evt_cnt[i*CW +: CW];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 1'b0; m_lvl[i] = 1'b0;
            last_tgl[i] = -100;
            m_due[i].delete();
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("pulse%0d", i), 32'(evt_pulse[i]), 32'(m_pulse(i)));
            chk($sformatf("vld%0d", i),   32'(evt_vld[i]),   32'(m_cnt[i] != 0));
            chk($sformatf("cnt%0d", i),   32'(cnt_of(i)),    32'(m_cnt[i]));
            chk($sformatf("ovf%0d", i),   32'(ovf[i]),       32'(m_ovf[i]));
        end
    endtask

    // Called at a negedge: apply inputs, advance the model to the state after
    // the coming posedge, clock, then compare at the following negedge.
    task automatic step(input logic [CH-1:0] t, input logic [CH-1:0] r, input logic c);
        bit inc, pop, set;
        tgl_in = t; evt_rdy = r; ovf_clr = c; tv = t;
        for (int i = 0; i < CH; i++) begin
            if (!rst_n) begin
                m_lvl[i] = 1'b0;
            end else begin
                inc = m_pulse(i);
                pop = (m_cnt[i] != 0) && r[i];
                set = inc && !pop && (m_cnt[i] == CMAX);
                if (inc && !pop && m_cnt[i] < CMAX) m_cnt[i]++;
                else if (!inc && pop)               m_cnt[i]--;
                m_ovf[i] = set ? 1'b1 : (c ? 1'b0 : m_ovf[i]);
                while (m_due[i].size() > 0 && m_due[i][0] <= cyc) void'(m_due[i].pop_front());
                // A level seen at edge cyc+1 shows as a pulse SS-1 edges later.
                if (t[i] != m_lvl[i]) begin
                    m_due[i].push_back(cyc + SS);
                    m_lvl[i] = t[i];
                    last_tgl[i] = cyc;
                end
            end
        end
        @(posedge clk); cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
    endtask

    task automatic toggle_spaced(input int ch, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            step(tv ^ (CH'(1) << ch), '0, 1'b0);
            for (int w = 1; w < gap; w++) step(tv, '0, 1'b0);
        end
    endtask

    initial begin
        logic [CH-1:0] nt, nr;
        int n;
        model_clear();
        @(negedge clk);
        check_all();

        // Reset held: toggling does nothing; release with levels at 0.
        for (int k = 0; k < 3; k++) step(CH'($urandom), '0, 1'b0);
        step('0, '0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step('0, '0, 1'b0);

        // Single event on ch0: pulse visible exactly after edge 2.
        step(4'b0001, '0, 1'b0);
        chk("se_p_e1", 32'(evt_pulse[0]), 32'd0);
        step(tv, '0, 1'b0);
        chk("se_p_e2", 32'(evt_pulse[0]), 32'd1);
        step(tv, '0, 1'b0);
        chk("se_p_e3", 32'(evt_pulse[0]), 32'd0);
        chk("se_cnt", 32'(cnt_of(0)), 32'd1);
        chk("se_vld", 32'(evt_vld[0]), 32'd1);
        step(tv, 4'b0001, 1'b0);
        chk("se_pop_vld", 32'(evt_vld[0]), 32'd0);

        // Backpressure on ch2, then drain.
        toggle_spaced(2, 5, 4);
        chk("bp_cnt", 32'(cnt_of(2)), 32'd5);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step(tv, 4'b0100, 1'b0);
            if (!evt_vld[2]) begin n = k; break; end
        end
        chk("bp_drain", 32'(n), 32'd5);
        step(tv, '0, 1'b0);

        // Saturation on ch1: overflow flag appears with the 16th event.
        for (int j = 1; j <= 17; j++) begin
            toggle_spaced(1, 1, 4);
            if (j == 15) chk("sat_ovf15", 32'(ovf[1]), 32'd0);
            if (j == 16) chk("sat_ovf16", 32'(ovf[1]), 32'd1);
        end
        chk("sat_cnt", 32'(cnt_of(1)), 32'd15);
        step(tv, '0, 1'b1);
        chk("clr_ovf", 32'(ovf[1]), 32'd0);
        chk("clr_cnt", 32'(cnt_of(1)), 32'd15);

        // inc and pop together at max: no change, no overflow.
        step(tv ^ 4'b0010, '0, 1'b0);
        step(tv, '0, 1'b0);
        step(tv, 4'b0010, 1'b0);
        chk("incpop_cnt", 32'(cnt_of(1)), 32'd15);
        chk("incpop_ovf", 32'(ovf[1]), 32'd0);
        step(tv, '0, 1'b0);

        // Overflow coinciding with ovf_clr keeps the flag.
        step(tv ^ 4'b0010, '0, 1'b0);
        step(tv, '0, 1'b0);
        step(tv, '0, 1'b1);
        chk("setclr_ovf", 32'(ovf[1]), 32'd1);

        // Drain everything and clear flags.
        for (int k = 0; k < 20; k++) step(tv, '1, 1'b0);
        step(tv, '0, 1'b1);

        // All channels at once.
        step(~tv, '0, 1'b0);
        step(tv, '0, 1'b0);
        chk("mc_pulse", 32'(evt_pulse), 32'hF);
        step(tv, '0, 1'b0);
        for (int i = 0; i < CH; i++) chk($sformatf("mc_cnt%0d", i), 32'(cnt_of(i)), 32'd1);

        // Reset mid-burst.
        step(~tv, '0, 1'b0);
        assert_reset();
        chk("rst_cnt", 32'(evt_cnt), 32'd0);
        chk("rst_vld", 32'(evt_vld), 32'd0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        rst_n = 1'b1;
        step('0, '0, 1'b0);

        // Randomised traffic respecting the minimum toggle spacing.
        for (int k = 0; k < 800; k++) begin
            nt = tv;
            for (int i = 0; i < CH; i++) begin
                if (cyc - last_tgl[i] >= SS + 1 && $urandom_range(0, 2) == 0) nt[i] = ~nt[i];
                nr[i] = ($urandom_range(0, 3) == 0);
            end
            if (k == 500) begin
                assert_reset();
                step(nt, nr, 1'b0);
                rst_n = 1'b1;
            end else begin
                step(nt, nr, $urandom_range(0, 15) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
